// File: rtl/sram_param_pkg.sv
// Shared types and helpers for sram_param: FSM state, default geometry, byte parity.
package sram_param_pkg;

   typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_e;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 7;

   // Even parity: the stored bit makes the 9-bit lane have an even number of ones.
   function automatic logic byte_par(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/sram_param_array.sv
// Storage-only array for sram_param: per-lane write enables, asynchronous read, no reset.
module sram_param_array #(
   parameter int NB     = 4,
   parameter int LANE_W = 8,
   parameter int ADDR_W = 7,
   parameter int DEPTH  = 128
) (
   input  logic                       Clk,
   input  logic [NB-1:0]              we,
   input  logic [ADDR_W-1:0]          addr,
   input  logic [NB-1:0][LANE_W-1:0]  wdata,
   output logic [NB-1:0][LANE_W-1:0]  rdata
);

   logic [NB-1:0][LANE_W-1:0] mem [DEPTH];

   always_ff @(posedge Clk) begin
      for (int i = 0; i < NB; i++) begin
         if (we[i]) mem[addr][i] <= wdata[i];
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/sram_param.sv
// Parametrised single-port SRAM with byte enables, Req/Ready handshake and clear sweeper.
// Optional per-byte even parity and Perr reporting when SRAM_PARAM_PARITY_EN is defined.
module sram_param
   import sram_param_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic                Req,
   input  logic                Rw,
   input  logic [ADDR_W-1:0]   Addr,
   input  logic [DATA_W-1:0]   Data_in,
   input  logic [DATA_W/8-1:0] Be,
   input  logic                Clr,
   output logic                Ready,
   output logic                Busy,
   output logic [DATA_W-1:0]   Data_out,
   output logic                Rvalid,
   output logic                Perr
);

   localparam int NB = DATA_W / 8;
`ifdef SRAM_PARAM_PARITY_EN
   localparam int LANE_W = 9;
`else
   localparam int LANE_W = 8;
`endif
   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic                rvalid_q, rvalid_d;
   logic                perr_q, perr_d;

   logic [NB-1:0]             arr_we;
   logic [ADDR_W-1:0]         arr_addr;
   logic [NB-1:0][LANE_W-1:0] arr_wdata, arr_rdata, wr_lanes;
   logic [DATA_W-1:0]         rd_data;
   logic [NB-1:0]             par_bad;
   logic                      in_range;

   assign in_range = ({1'b0, Addr} < DEPTH_L);

   for (genvar i = 0; i < NB; i++) begin : g_lane
`ifdef SRAM_PARAM_PARITY_EN
      assign wr_lanes[i] = {byte_par(Data_in[8*i +: 8]), Data_in[8*i +: 8]};
      assign par_bad[i]  = arr_rdata[i][8] ^ byte_par(arr_rdata[i][7:0]);
`else
      assign wr_lanes[i] = Data_in[8*i +: 8];
      assign par_bad[i]  = 1'b0;
`endif
      assign rd_data[8*i +: 8] = arr_rdata[i][7:0];
   end

   sram_param_array #(
      .NB(NB), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
   ) u_array (
      .Clk   (Clk),
      .we    (arr_we),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dout_d    = dout_q;
      rvalid_d  = 1'b0;
      perr_d    = 1'b0;
      arr_we    = '0;
      arr_addr  = Addr;
      arr_wdata = wr_lanes;
      case (state_q)
         CLEAR: begin
            // Zero data and parity together so a cleared word reads back clean.
            arr_we    = '1;
            arr_addr  = cnt_q;
            arr_wdata = '0;
            if (cnt_q == LAST) state_d = IDLE;
            else               cnt_d   = cnt_q + ADDR_W'(1);
         end
         IDLE: begin
            if (Clr) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end else if (Req) begin
               if (Rw) begin
                  if (in_range) arr_we = Be;
               end else begin
                  rvalid_d = 1'b1;
                  dout_d   = in_range ? rd_data : '0;
                  perr_d   = in_range & (|par_bad);
               end
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= CLEAR;
         cnt_q    <= '0;
         dout_q   <= '0;
         rvalid_q <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         rvalid_q <= rvalid_d;
         perr_q   <= perr_d;
      end
   end

   assign Ready    = (state_q == IDLE) && !Clr;
   assign Busy     = (state_q == CLEAR);
   assign Data_out = dout_q;
   assign Rvalid   = rvalid_q;
   assign Perr     = perr_q;

endmodule

// File: tb/tb_sram_param.sv
// Directed bench for sram_param at default geometry (32-bit words, 128 deep).
module tb_sram_param;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        Req = 1'b0;
   logic        Rw = 1'b0;
   logic [6:0]  Addr = '0;
   logic [31:0] Data_in = '0;
   logic [3:0]  Be = '0;
   logic        Clr = 1'b0;
   logic        Ready, Busy, Rvalid, Perr;
   logic [31:0] Data_out;

   int chk_cnt = 0;
   int pass_cnt = 0;

   sram_param dut (
      .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Rw(Rw), .Addr(Addr),
      .Data_in(Data_in), .Be(Be), .Clr(Clr), .Ready(Ready), .Busy(Busy),
      .Data_out(Data_out), .Rvalid(Rvalid), .Perr(Perr)
   );

   always #5 Clk = ~Clk;

   // Stimulus drivers; entered and left at 1 time unit after a rising edge.
   task automatic do_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] b);
      Req = 1'b1; Rw = 1'b1; Addr = a; Data_in = d; Be = b;
      @(posedge Clk); #1;
      Req = 1'b0; Rw = 1'b0; Be = '0;
   endtask

   task automatic do_read(input logic [6:0] a, output logic [31:0] d, output logic rv, output logic pe);
      Req = 1'b1; Rw = 1'b0; Addr = a;
      @(posedge Clk); #1;
      d = Data_out; rv = Rvalid; pe = Perr;
      Req = 1'b0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!Ready && n < 400) begin
         @(posedge Clk); #1;
         n++;
      end
   endtask

   task automatic test_reset();
      int n, busy_bad, errs;
      logic [31:0] d; logic rv, pe;
      repeat (2) @(posedge Clk);
      #1;
      chk_cnt++;
      if ({Busy, Ready, Rvalid, Perr, Data_out} !== {4'b1000, 32'h0})
         $display("FAIL reset_outputs got %b expected %b", {Busy, Ready, Rvalid, Perr, Data_out}, {4'b1000, 32'h0});
      else pass_cnt++;
      Rst_n = 1'b1;
      n = 0; busy_bad = 0;
      while (!Ready && n < 400) begin
         if (!Busy) busy_bad++;
         @(posedge Clk); #1;
         n++;
      end
      chk_cnt++;
      if (n !== 128) $display("FAIL reset_sweep_len got %0d expected 128", n);
      else pass_cnt++;
      chk_cnt++;
      if (busy_bad !== 0 || Busy !== 1'b0)
         $display("FAIL reset_busy got busy_bad=%0d busy_end=%b expected 0/0", busy_bad, Busy);
      else pass_cnt++;
      errs = 0;
      for (int a = 0; a < 128; a++) begin
         do_read(7'(a), d, rv, pe);
         if (d !== 32'h0 || rv !== 1'b1 || pe !== 1'b0) errs++;
      end
      chk_cnt++;
      if (errs !== 0) $display("FAIL reset_all_zero got %0d bad words expected 0", errs);
      else pass_cnt++;
   endtask

   task automatic test_write_read();
      logic [31:0] d; logic rv, pe;
      do_write(7'h05, 32'hDEADBEEF, 4'b1111);
      do_read(7'h05, d, rv, pe);
      chk_cnt++;
      if (d !== 32'hDEADBEEF || rv !== 1'b1 || pe !== 1'b0)
         $display("FAIL write_read got %h rv=%b pe=%b expected deadbeef rv=1 pe=0", d, rv, pe);
      else pass_cnt++;
      @(posedge Clk); #1;
      chk_cnt++;
      if (Rvalid !== 1'b0 || Data_out !== 32'hDEADBEEF)
         $display("FAIL rvalid_strobe_hold got rv=%b data=%h expected rv=0 data=deadbeef", Rvalid, Data_out);
      else pass_cnt++;
   endtask

   task automatic test_byte_merge();
      logic [31:0] d; logic rv, pe;
      do_write(7'h10, 32'h11223344, 4'hF);
      do_write(7'h10, 32'hAABBCCDD, 4'b0101);
      do_read(7'h10, d, rv, pe);
      chk_cnt++;
      if (d !== 32'h11BB33DD || rv !== 1'b1)
         $display("FAIL byte_merge got %h rv=%b expected 11bb33dd rv=1", d, rv);
      else pass_cnt++;
      do_write(7'h10, 32'hFFFFFFFF, 4'b0000);
      do_read(7'h10, d, rv, pe);
      chk_cnt++;
      if (d !== 32'h11BB33DD)
         $display("FAIL be_zero_noop got %h expected 11bb33dd", d);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int pulses;
      logic [31:0] d5;
      Req = 1'b1; Rw = 1'b1; Addr = 7'h20; Data_in = 32'hCAFEF00D; Be = 4'hF;
      @(posedge Clk); #1;
      Rw = 1'b0; Be = '0;
      @(posedge Clk); #1;
      chk_cnt++;
      if (Rvalid !== 1'b1 || Data_out !== 32'hCAFEF00D)
         $display("FAIL write_then_read got rv=%b data=%h expected rv=1 data=cafef00d", Rvalid, Data_out);
      else pass_cnt++;
      pulses = 0; d5 = '0;
      for (int i = 0; i < 10; i++) begin
         Addr = 7'(i);
         @(posedge Clk); #1;
         if (Rvalid === 1'b1) pulses++;
         if (i == 5) d5 = Data_out;
      end
      Req = 1'b0;
      chk_cnt++;
      if (pulses !== 10) $display("FAIL ten_reads got %0d pulses expected 10", pulses);
      else pass_cnt++;
      chk_cnt++;
      if (d5 !== 32'hDEADBEEF) $display("FAIL burst_data got %h expected deadbeef", d5);
      else pass_cnt++;
      @(posedge Clk); #1;
      chk_cnt++;
      if (Rvalid !== 1'b0) $display("FAIL burst_end_rvalid got %b expected 0", Rvalid);
      else pass_cnt++;
   endtask

   task automatic test_clr_req();
      int n;
      logic [31:0] d; logic rv, pe;
      Clr = 1'b1; Req = 1'b1; Rw = 1'b1; Addr = 7'h07; Data_in = 32'h12345678; Be = 4'hF;
      #1;
      chk_cnt++;
      if (Ready !== 1'b0) $display("FAIL clr_ready got %b expected 0", Ready);
      else pass_cnt++;
      @(posedge Clk); #1;
      Clr = 1'b0; Req = 1'b0; Rw = 1'b0; Be = '0;
      chk_cnt++;
      if (Busy !== 1'b1) $display("FAIL clr_busy got %b expected 1", Busy);
      else pass_cnt++;
      wait_ready(n);
      chk_cnt++;
      if (n !== 128) $display("FAIL clr_sweep_len got %0d expected 128", n);
      else pass_cnt++;
      do_read(7'h07, d, rv, pe);
      chk_cnt++;
      if (d !== 32'h0 || rv !== 1'b1) $display("FAIL clr_no_write got %h rv=%b expected 0 rv=1", d, rv);
      else pass_cnt++;
   endtask

   task automatic test_rst_mid_sweep();
      int n;
      logic [31:0] d; logic rv, pe;
      do_write(7'h05, 32'hA5A5A5A5, 4'hF);
      do_read(7'h05, d, rv, pe);
      chk_cnt++;
      if (d !== 32'hA5A5A5A5 || rv !== 1'b1) $display("FAIL pre_rst_read got %h rv=%b expected a5a5a5a5 rv=1", d, rv);
      else pass_cnt++;
      Rst_n = 1'b0;
      #1;
      chk_cnt++;
      if (Rvalid !== 1'b0 || Data_out !== 32'h0 || Busy !== 1'b1 || Ready !== 1'b0)
         $display("FAIL rst_mid_read got rv=%b data=%h busy=%b ready=%b expected 0/0/1/0", Rvalid, Data_out, Busy, Ready);
      else pass_cnt++;
      #1 Rst_n = 1'b1;
      repeat (60) @(posedge Clk);
      #1;
      Rst_n = 1'b0;
      #2 Rst_n = 1'b1;
      wait_ready(n);
      chk_cnt++;
      if (n !== 128) $display("FAIL rst_sweep_restart got %0d expected 128", n);
      else pass_cnt++;
      do_read(7'h05, d, rv, pe);
      chk_cnt++;
      if (d !== 32'h0) $display("FAIL rst_sweep_cleared got %h expected 0", d);
      else pass_cnt++;
   endtask

   task automatic test_parity();
      logic [31:0] d; logic rv, pe;
      do_write(7'h03, 32'h0F0F0F0F, 4'hF);
      do_read(7'h03, d, rv, pe);
      chk_cnt++;
      if (d !== 32'h0F0F0F0F || pe !== 1'b0)
         $display("FAIL parity_clean got %h pe=%b expected 0f0f0f0f pe=0", d, pe);
      else pass_cnt++;
`ifdef SRAM_PARAM_PARITY_EN
      dut.u_array.mem[3][0][0] = ~dut.u_array.mem[3][0][0];
      do_read(7'h03, d, rv, pe);
      chk_cnt++;
      if (d !== 32'h0F0F0F0E || rv !== 1'b1 || pe !== 1'b1)
         $display("FAIL parity_err got %h rv=%b pe=%b expected 0f0f0f0e rv=1 pe=1", d, rv, pe);
      else pass_cnt++;
`endif
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_merge();
      test_back_to_back();
      test_clr_req();
      test_rst_mid_sweep();
      test_parity();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
